// File: rtl/multiplier_defs_pkg.sv
// Shared definitions for the shift-add multiplier: state encodings, default
// operand width and the last-step count. Used by multiplier_ctrl and the
// output stage. Optional build macro: MULT_SIGNED_EN (signed Booth stepping).
package multiplier_defs;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_CNT_W     = 5;
  localparam int DEF_LAST_STEP = DEF_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/multiplier_step.sv
// One partial-product step of the multiplier: conditional add (or Booth
// add/sub when MULT_SIGNED_EN is defined) followed by a one-bit right shift
// of the {U,V} pair. Purely combinational.
module multiplier_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] x,
`ifdef MULT_SIGNED_EN
  input  logic             q,
  output logic             q_nxt,
`endif
  output logic [WIDTH-1:0] u_nxt,
  output logic [WIDTH-1:0] v_nxt
);
  logic [WIDTH:0] sum;

`ifdef MULT_SIGNED_EN
  // Booth recode on {v[0],q}; 33-bit sign-extended sum avoids overflow,
  // the arithmetic shift drops out as sum[WIDTH:1] into U.
  always_comb begin
    sum = {u[WIDTH-1], u};
    case ({v[0], q})
      2'b01:   sum = {u[WIDTH-1], u} + {x[WIDTH-1], x};
      2'b10:   sum = {u[WIDTH-1], u} - {x[WIDTH-1], x};
      default: sum = {u[WIDTH-1], u};
    endcase
  end
  assign q_nxt = v[0];
`else
  // Unsigned: add X when the outgoing multiplier bit is set; carry kept in sum[WIDTH].
  always_comb begin
    sum = {1'b0, u};
    if (v[0]) sum = {1'b0, u} + {1'b0, x};
  end
`endif

  // {sum,V} >> 1: carry lands in U's MSB, sum LSB becomes the new product bit in V.
  assign u_nxt = sum[WIDTH:1];
  assign v_nxt = {sum[0], v[WIDTH-1:1]};
endmodule

// File: rtl/multiplier_ctrl.sv
// Sequential controller for the 32-step shift-add multiplier. Owns U, V, the
// captured multiplicand and the IDLE/EXEC/DONE state with a start/done
// handshake. Build macro MULT_SIGNED_EN selects signed Booth stepping.
module multiplier_ctrl
  import multiplier_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic             op_clear,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] U,
  output logic [WIDTH-1:0] V,
  output logic             busy,
  output logic             op_done
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           st;
  logic [WIDTH-1:0] xr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] u_nxt, v_nxt;
`ifdef MULT_SIGNED_EN
  logic             q, q_nxt;
`endif

  multiplier_step #(.WIDTH(WIDTH)) u_step (
    .u     (U),
    .v     (V),
    .x     (xr),
`ifdef MULT_SIGNED_EN
    .q     (q),
    .q_nxt (q_nxt),
`endif
    .u_nxt (u_nxt),
    .v_nxt (v_nxt)
  );

  // FSM, counter and datapath registers; clear beats start in every state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st  <= IDLE;
      U   <= '0;
      V   <= '0;
      xr  <= '0;
      cnt <= '0;
`ifdef MULT_SIGNED_EN
      q   <= 1'b0;
`endif
    end else begin
      case (st)
        IDLE, DONE: begin
          if (op_clear) begin
            st  <= IDLE;
            U   <= '0;
            V   <= '0;
            cnt <= '0;
          end else if (op_start) begin
            st  <= EXEC;
            U   <= '0;
            V   <= multiplier;
            xr  <= multiplicand;
            cnt <= '0;
`ifdef MULT_SIGNED_EN
            q   <= 1'b0;
`endif
          end
        end
        EXEC: begin
          if (op_clear) begin
            st  <= IDLE;
            U   <= '0;
            V   <= '0;
            cnt <= '0;
          end else begin
            U   <= u_nxt;
            V   <= v_nxt;
`ifdef MULT_SIGNED_EN
            q   <= q_nxt;
`endif
            if (cnt == LAST) begin
              st  <= DONE;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          st  <= IDLE;
          U   <= '0;
          V   <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

  assign state   = st;
  assign busy    = (st == EXEC);
  assign op_done = (st == DONE);
endmodule

// File: tb/tb_multiplier_ctrl.sv
// Randomized self-checking bench for multiplier_ctrl; expected products come
// from plain 64-bit arithmetic, expected latency from the 32-step rule.
module tb_multiplier_ctrl;
  logic        clk = 1'b0;
  logic        reset_n, op_start, op_clear;
  logic [31:0] multiplicand, multiplier;
  logic [1:0]  state;
  logic [31:0] U, V;
  logic        busy, op_done;

  int vecs = 0;
  int errs = 0;

  multiplier_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .state(state), .U(U), .V(V), .busy(busy), .op_done(op_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  // Start an op, count EXEC cycles, then check DONE and the product.
  // hold_start keeps op_start high with scrambled operands during EXEC.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_start);
    int n;
    @(negedge clk);
    op_start = 1'b1; multiplicand = a; multiplier = b;
    @(negedge clk);
    if (!hold_start) op_start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (hold_start) begin multiplicand = $urandom; multiplier = $urandom; end
      @(negedge clk);
    end
    op_start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(n), 64'd32);
    chk({tag, "_state"}, 64'(state), 64'd2);
    chk({tag, "_done"}, 64'(op_done), 64'd1);
    chk({tag, "_prod"}, {U, V}, prod(a, b));
  endtask

  initial begin
    reset_n = 1'b0; op_start = 1'b0; op_clear = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_uv", {U, V}, 64'd0);
    chk("rst_flags", 64'({busy, op_done}), 64'd0);
    reset_n = 1'b1;

    run_op("3x5", 32'd3, 32'd5, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_held", 64'({op_done, busy}), 64'b10);
    chk("done_uv_held", {U, V}, prod(32'd3, 32'd5));

    run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // abort at step 10
    @(negedge clk);
    op_start = 1'b1; multiplicand = 32'd7; multiplier = 32'd9;
    @(negedge clk);
    op_start = 1'b0;
    repeat (10) @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("abort_state", 64'(state), 64'd0);
    chk("abort_uv", {U, V}, 64'd0);
    run_op("2x2", 32'd2, 32'd2, 1'b0);

    run_op("hold_start", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_op("6x7_b2b", 32'd6, 32'd7, 1'b0);

    // start and clear together in DONE
    @(negedge clk);
    op_start = 1'b1; op_clear = 1'b1;
    @(negedge clk);
    op_start = 1'b0; op_clear = 1'b0;
    chk("startclr_state", 64'(state), 64'd0);
    chk("startclr_uv", {U, V}, 64'd0);

    // reset mid-EXEC
    @(negedge clk);
    op_start = 1'b1; multiplicand = 32'd11; multiplier = 32'd13;
    @(negedge clk);
    op_start = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("midrst_state", 64'(state), 64'd0);
    chk("midrst_out", {U, V}, 64'd0);
    chk("midrst_flags", 64'({busy, op_done}), 64'd0);

`ifdef MULT_SIGNED_EN
    run_op("neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b0);
    chk("neg3x5_const", {U, V}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("min_sq", 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("min_sq_const", {U, V}, 64'h4000_0000_0000_0000);
`else
    chk("ffxff_const", prod(32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
`endif

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h8000_0000 | a[3:0];
      run_op($sformatf("rnd%0d", i), a, b, (i % 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/multiplier_ctrl.md
Name: multiplier_ctrl

Overview:
Sequential controller for the 32-bit shift-add multiplier datapath. It owns the U (high accumulator) and V (low/multiplier) registers and the IDLE/EXEC/DONE state. It steps one partial product per clock, 32 steps per operation.
The existing output stage (multiplier_os) consumes state, U and V directly and forms result = {U,V}. This block sits between the operand source and that stage, with a start/done handshake.

Parameters:
WIDTH, 32, operand width. Product is 2*WIDTH. Only 32 is verified.
CNT_W, 5, step-counter width, equal to clog2(WIDTH).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous active-low reset
op_start  input  1  pulse: load operands and begin; sampled in IDLE or DONE only
op_clear  input  1  return to IDLE and zero U/V; priority over op_start
multiplicand  input  WIDTH  operand X, captured on accepted op_start
multiplier  input  WIDTH  operand Y, captured into V on accepted op_start
state  output  2  IDLE=2'b00, EXEC=2'b01, DONE=2'b10
U  output  WIDTH  high accumulator / high product word
V  output  WIDTH  low word: multiplier bits shifting out, product bits shifting in
busy  output  1  1 while state==EXEC
op_done  output  1  1 while state==DONE, held until next start/clear

Behaviour:
- Reset, when reset_n=0 at a clk edge: state=IDLE, U=0, V=0, X reg=0, cnt=0, busy=0, op_done=0. Reset overrides everything, including mid-EXEC; the operation is lost.
- All registers update on posedge clk only. busy and op_done decode state combinationally.
- IDLE: U/V hold 0.
  - op_clear: stay in IDLE.
  - else op_start: U=0, V=multiplier, X=multiplicand, cnt=0, go to EXEC.
- EXEC, one step per cycle:
  - sum is 33 bits: {1'b0,U}+{1'b0,X} if V[0]=1, else {1'b0,U}.
  - Then {U,V} = {sum,V}>>1 as a 65-bit right shift. The carry enters U[31].
  - cnt increments. On the step where cnt==31, go to DONE and wrap cnt to 0.
  - op_start in EXEC is ignored; no restart or queueing.
  - op_clear in EXEC: go to IDLE, U=V=0, cnt=0. The operation is aborted.
- Latency: op_start accepted at edge k gives state=EXEC after edge k. After edge k+32, state=DONE and {U,V}=X*Y (unsigned 64-bit).
- DONE: U/V/X hold.
  - op_clear: go to IDLE and zero U/V.
  - else op_start: reload and go to EXEC (back-to-back operation; no IDLE cycle needed).
  - else stay in DONE.
- Simultaneous op_start and op_clear: op_clear wins in every state.
- Illegal state 2'b11: next edge goes to IDLE with U=V=0.
- Operand inputs are only sampled on an accepted start. Changing them during EXEC has no effect.

Optional Feature:
MULT_SIGNED_EN
- Defined: two's-complement radix-2 Booth.
  - Extra register q, cleared on start.
  - Each step looks at {V[0],q}: 01 adds X, 10 subtracts X, 00/11 makes no change.
  - Use a 33-bit sign-extended sum, then an arithmetic right shift of {sum,V,q}.
  - Same 32-step latency. {U,V} is the signed 64-bit product.
  - -2^31 * -2^31 = 0x4000000000000000.
- Undefined: unsigned behaviour as above, and no q register.

Decomposition:
- Shared package/header multiplier_defs holds:
  - state encodings IDLE/EXEC/DONE (2'b00/01/10)
  - WIDTH default
  - the last-step count constant, WIDTH-1
- Both multiplier_ctrl and multiplier_os use these.
- One natural sub-module: multiplier_step.
  - Combinational; inputs U, V, X (and q) give next U, V (and q).
  - Contains the add/sub and the shift, including the MULT_SIGNED_EN variant.
- The FSM and counter stay in multiplier_ctrl.

Test Plan:
- Reset, then X=3, Y=5, start: busy=1 for exactly 32 cycles, then state=DONE, {U,V}=64'd15, op_done=1 and held.
- X=Y=0xFFFFFFFF: {U,V}=0xFFFFFFFE00000001, checking the carry into U[31].
- Start with X=7, Y=9; pulse op_clear at step 10: next cycle state=IDLE, U=V=0. A new start with X=2, Y=2 gives 4.
- Hold op_start high throughout EXEC with changing operands: the result uses only the first-captured operands. In DONE, a start with X=6, Y=7 gives 42 after 32 more cycles.
- op_start and op_clear together in DONE: goes to IDLE. reset_n=0 mid-EXEC: all outputs 0 next edge.
- With MULT_SIGNED_EN: X=-3, Y=5 gives 0xFFFFFFFFFFFFFFF1. X=Y=0x80000000 gives 0x4000000000000000.
